reg_share_arbiter: RTL and testbench

Round-robin arbiter that shares one W-bit storage register among N requesters. Each requester requests ownership, writes the register only while granted, and releases by dropping its request. A hold-time limit forces release so no requester can starve the others. It sits between the requesting control blocks and the shared register, and drives the register's write path and hold behaviour.

---
 rtl/reg_share_arbiter.sv | 149 ++++++++++++++
 tb/tb_reg_share_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter
//
// Round-robin arbiter that shares one W-bit register among N requesters.
// A requester owns the register while granted, writes it through its own
// wr_en/wr_data lane, and gives it up by dropping req. Ownership is forcibly
// ended after MAX_HOLD grant cycles so that no requester can starve the
// others. Every release is followed by exactly one bubble cycle (GAP) with
// no grant before the next owner is chosen.
//
// Ports
//   clk      in   system clock, rising-edge
//   reset    in   synchronous active-high reset
//   req      in   [N]     level-sensitive ownership request per requester
//   wr_en    in   [N]     write strobe per requester (only the owner's counts)
//   wr_data  in   [N*W]   write data, requester i on bits [i*W +: W]
//   gnt      out  [N]     one-hot grant, zero when nobody owns the register
//   owner    out  [clog2(N)] index of the current owner, 0 when gnt == 0
//   busy     out  1       high while gnt != 0
//   timeout  out  1       one-cycle pulse in the GAP cycle after a forced release
//   q        out  [W]     shared register contents
module reg_share_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         wr_en,
    input  logic [N*W-1:0]       wr_data,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 timeout,
    output logic [W-1:0]         q
);

    localparam int PW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [HW-1:0]   hcnt, hcnt_nxt;
    logic [N-1:0]    gnt_nxt;
    logic [PW-1:0]   owner_nxt;
    logic            timeout_nxt;
    logic [W-1:0]    q_nxt;

    logic            found;
    logic [PW-1:0]   win;
    logic [PW-1:0]   idx;

    // Rotating priority search starting at ptr: first requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hcnt_nxt    = hcnt;
        gnt_nxt     = gnt;
        owner_nxt   = owner;
        timeout_nxt = 1'b0;
        q_nxt       = q;

        case (state)
            IDLE, GAP: begin
                // GAP arbitrates exactly like IDLE; ptr was already advanced
                // past the previous owner when it released.
                if (found) begin
                    state_nxt = OWNED;
                    gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << win;
                    owner_nxt = win;
                    hcnt_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    owner_nxt = '0;
                end
            end
            OWNED: begin
                hcnt_nxt = hcnt + HW'(1);
                if (!req[owner]) begin
                    // Voluntary release: no write is taken in this cycle.
                    state_nxt = GAP;
                    gnt_nxt   = '0;
                    owner_nxt = '0;
                    ptr_nxt   = PW'((int'(owner) + 1) % N);
                end else begin
                    if (wr_en[owner]) begin
                        q_nxt = wr_data[int'(owner)*W +: W];
                    end
                    // Forced release still honours the write of its last cycle.
                    if (hcnt == HW'(MAX_HOLD - 1)) begin
                        state_nxt   = GAP;
                        gnt_nxt     = '0;
                        owner_nxt   = '0;
                        ptr_nxt     = PW'((int'(owner) + 1) % N);
                        timeout_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                owner_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            hcnt    <= '0;
            gnt     <= '0;
            owner   <= '0;
            timeout <= 1'b0;
            q       <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            hcnt    <= hcnt_nxt;
            gnt     <= gnt_nxt;
            owner   <= owner_nxt;
            timeout <= timeout_nxt;
            q       <= q_nxt;
        end
    end

    assign busy = |gnt;

endmodule

// File: tb/tb_reg_share_arbiter.sv
module tb_reg_share_arbiter;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int MAX_HOLD = 8;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   wr_en;
    logic [N*W-1:0] wr_data;
    logic [N-1:0]   gnt;
    logic [1:0]     owner;
    logic           busy;
    logic           timeout;
    logic [W-1:0]   q;

    reg_share_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout),
        .q       (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: who owns the register (-1 = nobody), how many grant
    // cycles it has had so far, and which index has top priority next.
    int           m_own  = -1;
    int           m_held = 0;
    int           m_prio = 0;
    logic         m_to   = 1'b0;
    logic [W-1:0] m_q    = '0;

    task automatic model_tick(input logic r, input logic [N-1:0] rq,
                              input logic [N-1:0] we, input logic [N*W-1:0] wd);
        if (r) begin
            m_own = -1; m_held = 0; m_prio = 0; m_to = 1'b0; m_q = '0;
        end else if (m_own >= 0) begin
            m_to = 1'b0;
            if (!rq[m_own]) begin
                m_prio = (m_own + 1) % N;
                m_own  = -1;
            end else begin
                if (we[m_own]) m_q = wd[m_own*W +: W];
                if (m_held == MAX_HOLD) begin
                    m_to   = 1'b1;
                    m_prio = (m_own + 1) % N;
                    m_own  = -1;
                end else begin
                    m_held++;
                end
            end
        end else begin
            m_to = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (m_own < 0 && rq[(m_prio + k) % N]) begin
                    m_own  = (m_prio + k) % N;
                    m_held = 1;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, advance the model, sample after the edge.
    task automatic step(input logic r, input logic [N-1:0] rq,
                        input logic [N-1:0] we, input logic [N*W-1:0] wd);
        reset = r; req = rq; wr_en = we; wr_data = wd;
        model_tick(r, rq, we, wd);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [N-1:0] eg;
        eg = (m_own >= 0) ? (N'(1) << m_own) : '0;
        chk({tag, ".gnt"},     32'(gnt),     32'(eg));
        chk({tag, ".owner"},   32'(owner),   (m_own >= 0) ? 32'(m_own) : 32'd0);
        chk({tag, ".busy"},    32'(busy),    32'(m_own >= 0));
        chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
        chk({tag, ".q"},       32'(q),       32'(m_q));
    endtask

    typedef struct {
        logic         r;
        logic [3:0]   rq;
        logic [3:0]   we;
        logic [31:0]  wd;
        logic [3:0]   g;
        logic [1:0]   o;
        logic         to;
        logic [7:0]   eq;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // r  req    wr_en  wr_data        gnt    own    to    q
        tbl[0]  = '{1'b1, 4'hF, 4'hF, 32'hFFFFFFFF, 4'h0, 2'd0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 4'hA, 4'h5, 32'h12345678, 4'h0, 2'd0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 4'h4, 4'h0, 32'h00000000, 4'h4, 2'd2, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 4'h0, 4'h0, 32'h00000000, 4'h0, 2'd0, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 4'h2, 4'h0, 32'h00000000, 4'h2, 2'd1, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 4'h2, 4'hA, 32'h3C00A500, 4'h2, 2'd1, 1'b0, 8'hA5};
        tbl[6]  = '{1'b0, 4'h2, 4'h8, 32'h3C000000, 4'h2, 2'd1, 1'b0, 8'hA5};
        tbl[7]  = '{1'b0, 4'h0, 4'h0, 32'h00000000, 4'h0, 2'd0, 1'b0, 8'hA5};
        tbl[8]  = '{1'b0, 4'h4, 4'h0, 32'h00000000, 4'h4, 2'd2, 1'b0, 8'hA5};
        tbl[9]  = '{1'b0, 4'h4, 4'h4, 32'h00110000, 4'h4, 2'd2, 1'b0, 8'h11};
        tbl[10] = '{1'b1, 4'h4, 4'h4, 32'h00FF0000, 4'h0, 2'd0, 1'b0, 8'h00};
        tbl[11] = '{1'b0, 4'h6, 4'h0, 32'h00000000, 4'h2, 2'd1, 1'b0, 8'h00};
        tbl[12] = '{1'b0, 4'h0, 4'h0, 32'h00000000, 4'h0, 2'd0, 1'b0, 8'h00};

        reset = 1'b1; req = '0; wr_en = '0; wr_data = '0;

        // Table: reset, write isolation, reset during ownership.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].rq, tbl[i].we, tbl[i].wd);
            chk($sformatf("tbl%0d.gnt", i),     32'(gnt),     32'(tbl[i].g));
            chk($sformatf("tbl%0d.owner", i),   32'(owner),   32'(tbl[i].o));
            chk($sformatf("tbl%0d.busy", i),    32'(busy),    32'(|tbl[i].g));
            chk($sformatf("tbl%0d.timeout", i), 32'(timeout), 32'(tbl[i].to));
            chk($sformatf("tbl%0d.q", i),       32'(q),       32'(tbl[i].eq));
        end

        // Round-robin with all four requesting: order 0,1,2,3,0 with one bubble.
        step(1'b1, 4'h0, 4'h0, '0);
        begin
            int order[5] = '{0, 1, 2, 3, 0};
            for (int i = 0; i < 5; i++) begin
                step(1'b0, 4'hF, 4'h0, '0);
                chk($sformatf("rr%0d.first", i), 32'(gnt), 32'(4'b1 << order[i]));
                step(1'b0, 4'hF, 4'h0, '0);
                chk($sformatf("rr%0d.second", i), 32'(gnt), 32'(4'b1 << order[i]));
                step(1'b0, 4'hF & ~(4'b1 << order[i]), 4'h0, '0);
                chk($sformatf("rr%0d.gap", i), 32'(gnt), 32'd0);
            end
        end

        // Forced release of a sole requester, write on the last grant cycle.
        step(1'b1, 4'h0, 4'h0, '0);
        for (int c = 1; c <= 8; c++) begin
            step(1'b0, 4'h1, 4'h0, '0);
            chk($sformatf("hold%0d.gnt", c), 32'(gnt), 32'h1);
            chk($sformatf("hold%0d.timeout", c), 32'(timeout), 32'd0);
        end
        step(1'b0, 4'h1, 4'h1, 32'h0000005A);
        chk("force.gnt", 32'(gnt), 32'd0);
        chk("force.busy", 32'(busy), 32'd0);
        chk("force.timeout", 32'(timeout), 32'd1);
        chk("force.q", 32'(q), 32'h5A);
        step(1'b0, 4'h1, 4'h1, 32'h00000077);
        chk("regrant.gnt", 32'(gnt), 32'h1);
        chk("regrant.timeout", 32'(timeout), 32'd0);
        chk("gapwrite.q", 32'(q), 32'h5A);
        for (int c = 2; c <= 8; c++) step(1'b0, 4'h1, 4'h0, '0);
        chk("hold8b.gnt", 32'(gnt), 32'h1);
        step(1'b0, 4'h3, 4'h0, '0);
        chk("force2.gnt", 32'(gnt), 32'd0);
        chk("force2.timeout", 32'(timeout), 32'd1);
        step(1'b0, 4'h3, 4'h0, '0);
        chk("handoff.gnt", 32'(gnt), 32'h2);
        chk("handoff.owner", 32'(owner), 32'd1);

        // Randomized traffic against the reference model.
        begin
            logic [N-1:0] rq;
            rq = '0;
            for (int i = 0; i < 3000; i++) begin
                logic r;
                r = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 9) < 2) rq = N'($urandom);
                step(r, rq, N'($urandom), ($urandom));
                chk_model($sformatf("rnd%0d", i));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
